servo_pwm_gen: RTL and testbench

RC servo pulse generator: transmit-side counterpart of the RC pulse-measurement receiver. It accepts per-channel pulse-width commands over the 24-bit write channel and drives six servo/ESC outputs with standard RC PWM frames. Widths are double-buffered so outputs only change at frame boundaries and never glitch. The block sits beside the RC receiver on the host command bus and drives the servo pins directly.

---
 rtl/servo_pwm_gen.sv | 118 +++++++++++
 tb/tb_servo_pwm_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// RC servo pulse generator: double-buffered per-channel widths, one PWM frame every FRAME_US.
// Optional build macro SERVO_CLAMP_EN saturates written widths to [MIN_US, MAX_US].
module servo_pwm_gen #(
    parameter int CHANNELS = 6,
    parameter int WIDTH    = 17,
    parameter int CLK_MHZ  = 50,
    parameter int FRAME_US = 20000,
    parameter int MIN_US   = 500,
    parameter int MAX_US   = 2500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [23:0]         in_data,
    input  logic                in_wr,
    output logic [CHANNELS-1:0] servo,
    output logic                frame_stb
);

    localparam int PS_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam int FC_W = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

`ifdef SERVO_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    logic [PS_W-1:0]     presc_q, presc_d;
    logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [WIDTH-1:0]    shadow_width_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_width_d [CHANNELS];
    logic [WIDTH-1:0]    active_width_q [CHANNELS];
    logic [CHANNELS-1:0] shadow_en_q, shadow_en_d;
    logic [CHANNELS-1:0] active_en_q;
    logic [CHANNELS-1:0] servo_q, servo_d;
    logic                frame_stb_q;

    logic                us_tick;
    logic                frame_wrap;
    logic                frame_start;
    logic [2:0]          sel;
    logic [WIDTH-1:0]    wr_width;
    logic                unused_in;

    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH-1:0] w);
        if (w < WIDTH'(MIN_US))
            return WIDTH'(MIN_US);
        else if (w > WIDTH'(MAX_US))
            return WIDTH'(MAX_US);
        else
            return w;
    endfunction

    assign sel       = in_data[23:21];
    assign wr_width  = CLAMP_EN ? sat(in_data[WIDTH-1:0]) : in_data[WIDTH-1:0];
    assign unused_in = ^in_data[20:WIDTH];

    always_comb begin
        us_tick     = (presc_q == PS_W'(CLK_MHZ - 1));
        frame_wrap  = (frame_cnt_q == FC_W'(FRAME_US - 1));
        frame_start = us_tick && frame_wrap;
        presc_d     = us_tick ? '0 : presc_q + 1'b1;
        frame_cnt_d = frame_cnt_q;
        if (us_tick)
            frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + 1'b1;
    end

    // Command decode: selects between CHANNELS and 6 fall through untouched.
    always_comb begin
        shadow_width_d = shadow_width_q;
        shadow_en_d    = shadow_en_q;
        if (in_wr) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == 3'(i))
                    shadow_width_d[i] = wr_width;
            end
            if (sel == 3'd7)
                shadow_en_d = in_data[CHANNELS-1:0];
        end
    end

    always_comb begin
        servo_d = '0;
        for (int i = 0; i < CHANNELS; i++)
            servo_d[i] = active_en_q[i] && (WIDTH'(frame_cnt_q) < active_width_q[i]);
    end

    // Active set reloads only at frame start, so a write never reshapes a running pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            frame_cnt_q <= FC_W'(FRAME_US - 1);
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_width_q[i] <= '0;
                active_width_q[i] <= '0;
            end
            shadow_en_q <= '0;
            active_en_q <= '0;
            servo_q     <= '0;
            frame_stb_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            frame_cnt_q    <= frame_cnt_d;
            shadow_width_q <= shadow_width_d;
            shadow_en_q    <= shadow_en_d;
            if (frame_start) begin
                active_width_q <= shadow_width_q;
                active_en_q    <= shadow_en_q;
            end
            servo_q     <= servo_d;
            frame_stb_q <= frame_start;
        end
    end

    assign servo     = servo_q;
    assign frame_stb = frame_stb_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen: per-frame high-time counts against hand-computed widths.
module tb_servo_pwm_gen;

    localparam int CH        = 6;
    localparam int FRAME_CLK = 200;

`ifdef SERVO_CLAMP_EN
    localparam int E_W0   = 20;
    localparam int E_W150 = 100;
`else
    localparam int E_W0   = 0;
    localparam int E_W150 = 200;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [23:0]   in_data = '0;
    logic          in_wr = 1'b0;
    logic [CH-1:0] servo;
    logic          frame_stb;

    int total = 0;
    int bad   = 0;
    int hi_cnt [CH];
    int exp_hi [CH];
    int stb_at;

    servo_pwm_gen #(
        .CHANNELS(CH), .WIDTH(17), .CLK_MHZ(2), .FRAME_US(100), .MIN_US(10), .MAX_US(50)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_wr(in_wr),
        .servo(servo), .frame_stb(frame_stb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [23:0] word);
        in_data = word;
        in_wr   = 1'b1;
        @(negedge clk);
        in_wr   = 1'b0;
        in_data = '0;
    endtask

    // Called at a negedge with rst high; the strobe must be up in the third clock period.
    task automatic release_rst(input string tag);
        int n = 0;
        rst = 1'b0;
        while (!frame_stb && n < 10) begin
            @(negedge clk);
            n++;
            chk({tag, "_servo_low"}, int'(servo), 0);
        end
        chk({tag, "_first_stb"}, n, 2);
        @(negedge clk);
        chk({tag, "_stb_one_cycle"}, int'(frame_stb), 0);
    endtask

    // Counts high samples per channel over one whole frame, optionally writing at sample wr_at.
    task automatic measure(input int wr_at, input logic [23:0] wr_word);
        int n = 0;
        while (!frame_stb && n < 2 * FRAME_CLK) begin
            @(negedge clk);
            n++;
        end
        chk("stb_seen", int'(frame_stb), 1);
        for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
        stb_at = -1;
        for (int k = 0; k < FRAME_CLK; k++) begin
            in_wr   = (k == wr_at);
            in_data = (k == wr_at) ? wr_word : 24'h0;
            @(negedge clk);
            in_wr   = 1'b0;
            in_data = '0;
            for (int i = 0; i < CH; i++) if (servo[i]) hi_cnt[i]++;
            if (frame_stb && stb_at < 0) stb_at = k + 1;
        end
        chk("stb_period", stb_at, FRAME_CLK);
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < CH; i++)
            chk($sformatf("%s_ch%0d", tag, i), hi_cnt[i], exp_hi[i]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_servo", int'(servo), 0);
        chk("rst_stb", int'(frame_stb), 0);
        release_rst("boot");

        wr({3'd0, 21'd30});
        wr({3'd7, 21'h01});
        measure(-1, '0);
        exp_hi = '{60, 0, 0, 0, 0, 0};
        check_frame("f2");
        measure(-1, '0);
        check_frame("f3");

        wr({3'd2, 21'd40});
        wr({3'd7, 21'h05});
        measure(-1, '0);
        exp_hi = '{60, 0, 80, 0, 0, 0};
        check_frame("ch2_run");
        measure(60, {3'd2, 21'd20});
        check_frame("ch2_mid");
        measure(-1, '0);
        exp_hi = '{60, 0, 40, 0, 0, 0};
        check_frame("ch2_new");

        // Last sample's write lands on the frame-start edge itself.
        measure(FRAME_CLK - 1, {3'd0, 21'd45});
        check_frame("coin0");
        measure(-1, '0);
        check_frame("coin1");
        measure(-1, '0);
        exp_hi = '{90, 0, 40, 0, 0, 0};
        check_frame("coin2");

        wr({3'd3, 21'd0});
        wr({3'd4, 21'd150});
        wr({3'd5, 21'd25});
        wr({3'd6, 21'd33});
        wr({3'd7, 21'h1D});
        measure(-1, '0);
        exp_hi = '{90, 0, 40, E_W0, E_W150, 0};
        check_frame("edge");
        measure(-1, '0);
        check_frame("edge2");

        repeat (10) @(negedge clk);
        chk("pre_rst_high", int'(servo[0]), 1);
        #2 rst = 1'b1;
        #1 chk("rst_async", int'(servo), 0);
        repeat (2) @(negedge clk);
        release_rst("rerun");
        measure(-1, '0);
        exp_hi = '{0, 0, 0, 0, 0, 0};
        check_frame("post_rst");
        wr({3'd7, 21'h3F});
        measure(-1, '0);
        measure(-1, '0);
        check_frame("en_only");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
